robot_vacuum_controller: RTL

Consumes the scheduler's start_cleaning level and runs one full cleaning mission: leave dock, clean for a fixed time, return, re-dock.
- Supervises battery, bumper-stuck and dock-return timeout; reports mission status and exit reason.
- Sits between the scheduler and the motor/brush drivers; all timing derives from an external 1 Hz tick.

---
 rtl/robot_vacuum_pkg.sv | 39 +++
 rtl/rv_sec_timer.sv | 29 ++
 rtl/robot_vacuum_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/robot_vacuum_pkg.sv
// rtl/robot_vacuum_pkg.sv - shared states, exit codes and state-to-output decode
package robot_vacuum_pkg;

  typedef enum logic [1:0] {
    DOCKED    = 2'd0,
    CLEANING  = 2'd1,
    RETURNING = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [1:0] EXIT_COMPLETE = 2'd0;
  localparam logic [1:0] EXIT_LOW_BATT = 2'd1;
  localparam logic [1:0] EXIT_ABORT    = 2'd2;
  localparam logic [1:0] EXIT_FAULT    = 2'd3;

  localparam int BATT_W = 7;

  typedef struct packed {
    logic docked;
    logic busy;
    logic motor_en;
    logic brush_en;
    logic fault;
  } outs_t;

  function automatic outs_t state_outs(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      DOCKED:    o.docked = 1'b1;
      CLEANING:  begin o.busy = 1'b1; o.motor_en = 1'b1; o.brush_en = 1'b1; end
      RETURNING: begin o.busy = 1'b1; o.motor_en = 1'b1; end
      FAULT:     o.fault = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rv_sec_timer.sv
// rtl/rv_sec_timer.sv - tick-driven seconds counter with clear, enable, saturation and terminal hit
module rv_sec_timer #(
  parameter int TW       = 12,
  parameter int TERMINAL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          hit
);

  localparam logic [TW-1:0] LAST = TW'(TERMINAL - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && tick && (count != '1))
      count <= count + TW'(1);
  end

  // hit marks the tick that carries the count onto TERMINAL
  assign hit = en && tick && (count == LAST);

endmodule

// File: rtl/robot_vacuum_controller.sv
// rtl/robot_vacuum_controller.sv - cleaning mission FSM; ROBOT_VACUUM_RESUME_EN adds low-battery resume
module robot_vacuum_controller
  import robot_vacuum_pkg::*;
#(
  parameter int CLEAN_SECONDS  = 1800,
  parameter int RETURN_TIMEOUT = 300,
  parameter int MIN_START_BATT = 50,
  parameter int LOW_BATT       = 20,
  parameter int STUCK_SECONDS  = 5,
  parameter int TW             = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_cleaning,
  input  logic              tick_1s,
  input  logic [BATT_W-1:0] battery_pct,
  input  logic              bumper,
  input  logic              dock_present,
  input  logic              abort,
  input  logic              clear_fault,
  output logic              motor_en,
  output logic              brush_en,
  output logic              docked,
  output logic              busy,
  output logic              fault,
  output logic              done,
  output logic              start_rejected,
  output logic [1:0]        exit_code,
  output logic [TW-1:0]     elapsed_sec
);

  localparam logic [BATT_W-1:0] MIN_B = BATT_W'(MIN_START_BATT);
  localparam logic [BATT_W-1:0] LOW_B = BATT_W'(LOW_BATT);
  localparam int                SW    = $clog2(STUCK_SECONDS + 1);
  localparam logic [SW-1:0]     STUCK_LAST = SW'(STUCK_SECONDS - 1);

  state_t        state;
  logic          start_prev;
  logic [SW-1:0] stuck_cnt;
  logic          start_edge, batt_ok, batt_low;
  logic          clean_clear, clean_hit, ret_hit, resume_go;
  logic [TW-1:0] ret_count_unused;

  assign start_edge  = start_cleaning && !start_prev;
  assign batt_ok     = battery_pct >= MIN_B;
  assign batt_low    = battery_pct < LOW_B;
  assign clean_clear = (state == DOCKED) && start_edge && batt_ok;

`ifdef ROBOT_VACUUM_RESUME_EN
  logic resume_pending;
  assign resume_go = resume_pending && batt_ok && !abort;
`else
  assign resume_go = 1'b0;
`endif

  rv_sec_timer #(.TW(TW), .TERMINAL(CLEAN_SECONDS)) u_clean_timer (
    .clk(clk), .rst(rst), .clear(clean_clear), .en(state == CLEANING),
    .tick(tick_1s), .count(elapsed_sec), .hit(clean_hit)
  );

  rv_sec_timer #(.TW(TW), .TERMINAL(RETURN_TIMEOUT)) u_return_timer (
    .clk(clk), .rst(rst), .clear(state != RETURNING), .en(state == RETURNING),
    .tick(tick_1s), .count(ret_count_unused), .hit(ret_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DOCKED;
      {docked, busy, motor_en, brush_en, fault} <= state_outs(DOCKED);
      done           <= 1'b0;
      start_rejected <= 1'b0;
      exit_code      <= EXIT_COMPLETE;
      start_prev     <= 1'b0;
      stuck_cnt      <= '0;
`ifdef ROBOT_VACUUM_RESUME_EN
      resume_pending <= 1'b0;
`endif
    end else begin
      start_prev     <= start_cleaning;
      done           <= 1'b0;
      start_rejected <= 1'b0;
      case (state)
        DOCKED: begin
`ifdef ROBOT_VACUUM_RESUME_EN
          if (start_edge || abort || resume_go) resume_pending <= 1'b0;
`endif
          if (start_edge && batt_ok) begin
            state     <= CLEANING;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(CLEANING);
            exit_code <= EXIT_COMPLETE;
            stuck_cnt <= '0;
          end else if (start_edge) begin
            start_rejected <= 1'b1;
          end else if (resume_go) begin
            // elapsed_sec is deliberately kept so only the remainder is cleaned
            state     <= CLEANING;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(CLEANING);
            stuck_cnt <= '0;
          end
        end
        CLEANING: begin
          if (tick_1s) stuck_cnt <= bumper ? stuck_cnt + SW'(1) : '0;
          if (tick_1s && bumper && (stuck_cnt == STUCK_LAST)) begin
            state     <= FAULT;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(FAULT);
            exit_code <= EXIT_FAULT;
            done      <= 1'b1;
          end else if (abort || batt_low || clean_hit) begin
            state     <= RETURNING;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(RETURNING);
            exit_code <= abort ? EXIT_ABORT : (batt_low ? EXIT_LOW_BATT : EXIT_COMPLETE);
          end
        end
        RETURNING: begin
          if (dock_present) begin
            state <= DOCKED;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(DOCKED);
            done  <= 1'b1;
`ifdef ROBOT_VACUUM_RESUME_EN
            if (exit_code == EXIT_LOW_BATT) resume_pending <= 1'b1;
`endif
          end else if (ret_hit) begin
            state     <= FAULT;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(FAULT);
            exit_code <= EXIT_FAULT;
            done      <= 1'b1;
          end
        end
        FAULT: begin
          if (clear_fault && dock_present) begin
            state <= DOCKED;
            {docked, busy, motor_en, brush_en, fault} <= state_outs(DOCKED);
          end
        end
        default: begin
          state <= DOCKED;
          {docked, busy, motor_en, brush_en, fault} <= state_outs(DOCKED);
        end
      endcase
    end
  end

endmodule
